stream_to_register_fifo: RTL and testbench

- Receive-side companion to the register-to-stream command path: it accepts an AXI-Stream (e.g. SPI RX data) into a FIFO and exposes it to software through the register server interface.
- Sits behind the AXI4-Lite subordinate's register interface.
- Software drains the FIFO by reading a DATA register and polls or clears state through a STATUS register.

---
 rtl/stream_to_register_fifo.sv | 117 +++++++++++
 tb/tb_stream_to_register_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_register_fifo.sv
// Receive-side stream FIFO exposed to software through the register server
// interface. The stream side fills the FIFO. Reading the DATA register pops the
// head entry. The STATUS register reports empty, full, sticky underflow and the
// fill count, and a write to STATUS with bit 0 set flushes the FIFO.
module stream_to_register_fifo #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned REGISTER_ADDR_BITS = 8,
    parameter int unsigned DEPTH              = 16,
    parameter int unsigned DATA_REGISTER_NO   = 1,
    parameter int unsigned STATUS_REGISTER_NO = 2
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          wren,
    input  logic [REGISTER_ADDR_BITS-1:0] wreg_no,
    input  logic [DATA_WIDTH-1:0]         wreg_data,
    input  logic                          rden,
    input  logic [REGISTER_ADDR_BITS-1:0] rreg_no,
    output logic [DATA_WIDTH-1:0]         rreg_data,
    output logic                          data_avail
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [REGISTER_ADDR_BITS-1:0] DATA_REG   = REGISTER_ADDR_BITS'(DATA_REGISTER_NO);
    localparam logic [REGISTER_ADDR_BITS-1:0] STATUS_REG = REGISTER_ADDR_BITS'(STATUS_REGISTER_NO);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  underflow;

    logic empty;
    logic full;
    logic flush;
    logic push;
    logic pop;
    logic data_read;
    logic status_read;
    logic unused_wdata_bits;

    // Handshake and strobe decode; ready never depends on a same-cycle pop
    always_comb begin
        empty       = (count == '0);
        full        = (count == FULL_COUNT);
        flush       = wren && (wreg_no == STATUS_REG) && wreg_data[0];
        s_tready    = ~areset && ~full && ~flush;
        push        = s_tvalid && s_tready;
        data_read   = rden && (rreg_no == DATA_REG);
        status_read = rden && (rreg_no == STATUS_REG);
        pop         = data_read && ~empty;
        data_avail  = ~empty;
    end

    // Only bit 0 of a STATUS write carries meaning
    assign unused_wdata_bits = ^wreg_data[DATA_WIDTH-1:1];

    // Pointer, count and sticky underflow state; flush takes priority over traffic
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (data_read && empty) begin
                underflow <= 1'b1;
            end else if (status_read) begin
                underflow <= 1'b0;
            end
        end
    end

    // Storage array, no reset needed since contents behind the pointers are don't-care
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // Combinational register read mux, sampled by the subordinate in the rden cycle
    always_comb begin
        rreg_data = '0;
        if (rreg_no == DATA_REG) begin
            if (!empty) begin
                rreg_data = mem[rd_ptr];
            end
        end else if (rreg_no == STATUS_REG) begin
            rreg_data[0]       = empty;
            rreg_data[1]       = full;
            rreg_data[2]       = underflow;
            rreg_data[16 +: CW] = count;
        end
    end

endmodule

// File: tb/tb_stream_to_register_fifo.sv
// Scoreboard bench for stream_to_register_fifo: register reads queue their
// expected data, and a monitor compares rreg_data in every rden cycle.
module tb_stream_to_register_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] R_DATA   = 8'd1;
    localparam logic [AW-1:0] R_STATUS = 8'd2;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          wren;
    logic [AW-1:0] wreg_no;
    logic [DW-1:0] wreg_data;
    logic          rden;
    logic [AW-1:0] rreg_no;
    logic [DW-1:0] rreg_data;
    logic          data_avail;

    typedef struct {
        string         name;
        logic [DW-1:0] value;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_q[$];
    int            passed = 0;
    int            total  = 0;

    stream_to_register_fifo dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .wren       (wren),
        .wreg_no    (wreg_no),
        .wreg_data  (wreg_data),
        .rden       (rden),
        .rreg_no    (rreg_no),
        .rreg_data  (rreg_data),
        .data_avail (data_avail)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Monitor: every read strobe consumes one scoreboard entry
    always @(negedge aclk) begin
        if (rden) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_read: rreg_data=0x%08h with no expected entry", rreg_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rreg_data === e.value) begin
                    passed++;
                end else begin
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, rreg_data, e.value);
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        bit done;
        done     = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge aclk);
            if (s_tready) begin
                done = 1'b1;
            end
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL push_timeout: s_tready stayed 0 for beat 0x%08h", d);
        end
    endtask

    task automatic read_reg(input string name, input logic [AW-1:0] no, input logic [DW-1:0] exp);
        exp_t e;
        e.name  = name;
        e.value = exp;
        exp_q.push_back(e);
        rden    = 1'b1;
        rreg_no = no;
        @(posedge aclk);
        #1;
        rden = 1'b0;
    endtask

    task automatic write_reg(input logic [AW-1:0] no, input logic [DW-1:0] d);
        wren      = 1'b1;
        wreg_no   = no;
        wreg_data = d;
        @(posedge aclk);
        #1;
        wren = 1'b0;
    endtask

    initial begin
        areset    = 1'b1;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        wren      = 1'b0;
        wreg_no   = '0;
        wreg_data = '0;
        rden      = 1'b0;
        rreg_no   = '0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("ready_in_reset", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("ready_after_reset", 32'(s_tready), 32'd1);
        check("avail_after_reset", 32'(data_avail), 32'd0);
        @(posedge aclk);
        #1;
        read_reg("status_reset", R_STATUS, 32'h0000_0001);

        // Basic ordering
        push(32'h11);
        push(32'h22);
        push(32'h33);
        @(negedge aclk);
        check("avail_three", 32'(data_avail), 32'd1);
        @(posedge aclk);
        #1;
        read_reg("data_11", R_DATA, 32'h11);
        read_reg("data_22", R_DATA, 32'h22);
        read_reg("data_33", R_DATA, 32'h33);
        read_reg("status_drained", R_STATUS, 32'h0000_0001);

        // Fill to full, then hold a 17th beat until one pop
        for (int i = 0; i < 16; i++) push(32'(i));
        @(negedge aclk);
        check("ready_full", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        read_reg("status_full", R_STATUS, 32'h0010_0002);
        s_tdata  = 32'h99;
        s_tvalid = 1'b1;
        @(negedge aclk);
        check("ready_held_full", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        read_reg("data_full_head", R_DATA, 32'h0);
        push(32'h99);
        @(negedge aclk);
        check("ready_refull", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        read_reg("status_refull", R_STATUS, 32'h0010_0002);
        for (int i = 1; i < 16; i++) read_reg("data_fill", R_DATA, 32'(i));
        read_reg("data_17th", R_DATA, 32'h99);
        read_reg("status_after_fill", R_STATUS, 32'h0000_0001);

        // Underflow sticky: set by empty DATA read, cleared by STATUS read
        read_reg("data_empty", R_DATA, 32'h0);
        read_reg("status_underflow", R_STATUS, 32'h0000_0005);
        read_reg("status_uf_cleared", R_STATUS, 32'h0000_0001);

        // Simultaneous pop and push with one entry queued
        push(32'hA0);
        s_tdata  = 32'hA1;
        s_tvalid = 1'b1;
        read_reg("data_pop_push", R_DATA, 32'hA0);
        s_tvalid = 1'b0;
        read_reg("status_pop_push", R_STATUS, 32'h0001_0000);
        read_reg("data_after_pp", R_DATA, 32'hA1);

        // Empty push and read together: read sees empty, beat still stored
        s_tdata  = 32'hB0;
        s_tvalid = 1'b1;
        read_reg("data_empty_push", R_DATA, 32'h0);
        s_tvalid = 1'b0;
        read_reg("status_empty_push", R_STATUS, 32'h0001_0004);
        read_reg("data_empty_push_beat", R_DATA, 32'hB0);

        // 40 beats with interleaved reads across pointer wrap
        for (int i = 0; i < 5; i++) begin
            push(32'h100 + 32'(i));
            model_q.push_back(32'h100 + 32'(i));
        end
        for (int i = 5; i < 40; i++) begin
            push(32'h100 + 32'(i));
            model_q.push_back(32'h100 + 32'(i));
            read_reg("data_wrap", R_DATA, model_q.pop_front());
        end
        while (model_q.size() > 0) read_reg("data_wrap_drain", R_DATA, model_q.pop_front());
        read_reg("status_wrap_done", R_STATUS, 32'h0000_0001);

        // Ignored writes, then flush while the stream is offering data
        read_reg("data_empty_again", R_DATA, 32'h0);
        for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
        write_reg(R_DATA, 32'h1);
        write_reg(R_STATUS, 32'h2);
        write_reg(8'd7, 32'h1);
        read_reg("status_ignored_writes", R_STATUS, 32'h0005_0004);
        read_reg("data_after_ignored", R_DATA, 32'h300);
        s_tdata   = 32'hF0;
        s_tvalid  = 1'b1;
        wren      = 1'b1;
        wreg_no   = R_STATUS;
        wreg_data = 32'h1;
        @(negedge aclk);
        check("ready_during_flush", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        wren     = 1'b0;
        s_tvalid = 1'b0;
        @(negedge aclk);
        check("avail_after_flush", 32'(data_avail), 32'd0);
        @(posedge aclk);
        #1;
        read_reg("status_after_flush", R_STATUS, 32'h0000_0001);

        // Reset mid-operation discards queued data
        push(32'h400);
        push(32'h401);
        areset = 1'b1;
        @(negedge aclk);
        check("ready_mid_reset", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("ready_post_reset", 32'(s_tready), 32'd1);
        check("avail_post_reset", 32'(data_avail), 32'd0);
        @(posedge aclk);
        #1;
        read_reg("status_post_reset", R_STATUS, 32'h0000_0001);
        read_reg("data_post_reset", R_DATA, 32'h0);

        repeat (2) @(posedge aclk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
